// File: rtl/cache_pkg.sv
// Shared types, derived geometry and address-slicing helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int INDEX_W   = 6;
    localparam int TAG_WIDTH = ADDR_W - INDEX_W;
    localparam int LINES     = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        MEM_WR,
        RESP
    } cache_state_t;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W-1:0];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:INDEX_W];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tags and data are don't-care while invalid.
module cache_array
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_W,
    parameter int TAG_BITS    = TAG_WIDTH,
    parameter int DATA_WIDTH  = DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_BITS-1:0]    wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data
);

    localparam int NUM_LINES = 1 << INDEX_WIDTH;

    logic [NUM_LINES-1:0]  valid;
    logic [TAG_BITS-1:0]   tags [NUM_LINES];
    logic [DATA_WIDTH-1:0] data [NUM_LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// load/store stage and main_memory; FSM and memory handshake live here.
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int INDEX_WIDTH = INDEX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_WIDTH-1:0] mem_add,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

    cache_state_t          state, state_n;
    logic                  first, first_n;
    logic [DATA_WIDTH-1:0] cpu_rdata_n;
    logic                  cpu_ready_n;
    logic [ADDR_WIDTH-1:0] mem_add_n;
    logic [DATA_WIDTH-1:0] mem_write_data_n;
    logic                  mem_read_n;
    logic                  mem_write_n;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit;
    logic                  arr_wr_en;
    logic [INDEX_WIDTH-1:0] arr_wr_index;
    logic [TAG_W-1:0]      arr_wr_tag;
    logic [DATA_WIDTH-1:0] arr_wr_data;

    cache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_BITS    (TAG_W),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (addr_index(cpu_addr)),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_wr_en),
        .wr_index (arr_wr_index),
        .wr_tag   (arr_wr_tag),
        .wr_data  (arr_wr_data)
    );

    assign hit = rd_valid && (rd_tag == addr_tag(cpu_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            first          <= 1'b0;
            cpu_rdata      <= '0;
            cpu_ready      <= 1'b0;
            mem_add        <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            state          <= state_n;
            first          <= first_n;
            cpu_rdata      <= cpu_rdata_n;
            cpu_ready      <= cpu_ready_n;
            mem_add        <= mem_add_n;
            mem_write_data <= mem_write_data_n;
            mem_read       <= mem_read_n;
            mem_write      <= mem_write_n;
        end
    end

    // mem_ready seen on the first edge of a request predates it, so 'first' masks it.
    always_comb begin
        state_n          = state;
        first_n          = 1'b0;
        cpu_rdata_n      = cpu_rdata;
        cpu_ready_n      = 1'b0;
        mem_add_n        = mem_add;
        mem_write_data_n = mem_write_data;
        mem_read_n       = mem_read;
        mem_write_n      = mem_write;
        arr_wr_en        = 1'b0;
        arr_wr_index     = addr_index(mem_add);
        arr_wr_tag       = addr_tag(mem_add);
        arr_wr_data      = mem_read_data;

        case (state)
            IDLE: begin
                if (cpu_write) begin
                    mem_add_n        = cpu_addr;
                    mem_write_data_n = cpu_wdata;
                    mem_write_n      = 1'b1;
                    first_n          = 1'b1;
                    state_n          = MEM_WR;
                    if (hit) begin
                        arr_wr_en    = 1'b1;
                        arr_wr_index = addr_index(cpu_addr);
                        arr_wr_tag   = addr_tag(cpu_addr);
                        arr_wr_data  = cpu_wdata;
                    end
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata_n = rd_data;
                        cpu_ready_n = 1'b1;
                        state_n     = RESP;
                    end else begin
                        mem_add_n  = cpu_addr;
                        mem_read_n = 1'b1;
                        first_n    = 1'b1;
                        state_n    = MEM_RD;
                    end
                end
            end
            MEM_RD: begin
                if (!first && mem_ready) begin
                    arr_wr_en   = 1'b1;
                    cpu_rdata_n = mem_read_data;
                    mem_read_n  = 1'b0;
                    cpu_ready_n = 1'b1;
                    state_n     = RESP;
                end
            end
            MEM_WR: begin
                if (!first && mem_ready) begin
                    mem_write_n = 1'b0;
                    cpu_ready_n = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a vector table of loads/stores against a small
// main_memory model, plus a hand-written reset-during-miss sequence.
module tb_data_cache;

    logic        clk;
    logic        reset;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [11:0] mem_add;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    logic [31:0] mem_model [4096];

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_rd_cycles;
        int          exp_wr_cycles;
    } vec_t;

    vec_t vecs [12];

    data_cache dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_add        (mem_add),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main_memory: ready and read data registered one edge after the request is sampled
    always @(posedge clk) begin
        mem_ready <= mem_read | mem_write;
        if (mem_write) begin
            mem_model[mem_add] <= mem_write_data;
        end else if (mem_read) begin
            mem_read_data <= mem_model[mem_add];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat    = 0;
        int rd_cyc = 0;
        int wr_cyc = 0;
        bit done   = 1'b0;
        bit both   = 1'b0;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_read  = v.rd;
        cpu_write = v.wr;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read && mem_write) both = 1'b1;
            if (cpu_ready) done = 1'b1;
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        check_output($sformatf("%s completes", v.name), 32'(done), 32'd1);
        check_output($sformatf("%s latency", v.name), 32'(lat), 32'(v.exp_lat));
        check_output($sformatf("%s rdata", v.name), cpu_rdata, v.exp_rdata);
        check_output($sformatf("%s mem_read cycles", v.name), 32'(rd_cyc), 32'(v.exp_rd_cycles));
        check_output($sformatf("%s mem_write cycles", v.name), 32'(wr_cyc), 32'(v.exp_wr_cycles));
        check_output($sformatf("%s rd/wr exclusive", v.name), 32'(both), 32'd0);
        if (v.wr) begin
            check_output($sformatf("%s memory word", v.name), mem_model[v.addr], v.wdata);
        end
        @(negedge clk);
        check_output($sformatf("%s ready one cycle", v.name), 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'(i);
        mem_model[12'h005] = 32'hDEADBEEF;
        mem_model[12'h045] = 32'h11110045;
        mem_model[12'h020] = 32'h55667788;

        //            name            rd    wr    addr     wdata          lat rdata         rdc wrc
        vecs[0]  = '{"cold read 005", 1'b1, 1'b0, 12'h005, 32'h0,          3, 32'hDEADBEEF, 2, 0};
        vecs[1]  = '{"hit read 005",  1'b1, 1'b0, 12'h005, 32'h0,          1, 32'hDEADBEEF, 0, 0};
        vecs[2]  = '{"write hit 005", 1'b0, 1'b1, 12'h005, 32'h12345678,   3, 32'hDEADBEEF, 0, 2};
        vecs[3]  = '{"reread 005",    1'b1, 1'b0, 12'h005, 32'h0,          1, 32'h12345678, 0, 0};
        vecs[4]  = '{"write miss 045",1'b0, 1'b1, 12'h045, 32'hAAAA0000,   3, 32'h12345678, 0, 2};
        vecs[5]  = '{"005 untouched", 1'b1, 1'b0, 12'h005, 32'h0,          1, 32'h12345678, 0, 0};
        vecs[6]  = '{"conflict 045",  1'b1, 1'b0, 12'h045, 32'h0,          3, 32'hAAAA0000, 2, 0};
        vecs[7]  = '{"evicted 005",   1'b1, 1'b0, 12'h005, 32'h0,          3, 32'h12345678, 2, 0};
        vecs[8]  = '{"rd+wr 010",     1'b1, 1'b1, 12'h010, 32'h0BADF00D,   3, 32'h12345678, 0, 2};
        vecs[9]  = '{"read 010",      1'b1, 1'b0, 12'h010, 32'h0,          3, 32'h0BADF00D, 2, 0};
        vecs[10] = '{"post-rst 020",  1'b1, 1'b0, 12'h020, 32'h0,          3, 32'h55667788, 2, 0};
        vecs[11] = '{"post-rst 010",  1'b1, 1'b0, 12'h010, 32'h0,          3, 32'h0BADF00D, 2, 0};

        repeat (3) @(negedge clk);
        check_output("reset cpu_ready", 32'(cpu_ready), 32'd0);
        check_output("reset mem_read", 32'(mem_read), 32'd0);
        check_output("reset mem_write", 32'(mem_write), 32'd0);
        check_output("reset cpu_rdata", cpu_rdata, 32'd0);
        check_output("reset mem_add", 32'(mem_add), 32'd0);
        check_output("reset mem_write_data", mem_write_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

        // Reset lands while the miss to 0x020 is waiting on memory
        cpu_addr = 12'h020;
        cpu_read = 1'b1;
        @(negedge clk);
        check_output("abort mem_read before reset", 32'(mem_read), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("abort mem_read async", 32'(mem_read), 32'd0);
        check_output("abort mem_add async", 32'(mem_add), 32'd0);
        check_output("abort cpu_rdata async", cpu_rdata, 32'd0);
        cpu_read = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("abort no cpu_ready", 32'(cpu_ready), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int i = 10; i < 12; i++) apply_stimulus(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache placed between the CPU load/store stage and `main_memory`. It serves read hits from a local array in a single cycle and fills lines on read misses. Every store is forwarded to `main_memory` and updates the local copy on a hit. The memory-side port speaks the `main_memory` protocol: level request, `ready` registered one edge after the request is sampled.

## Interface
- `ADDR_WIDTH`, 12, word address width; matches `main_memory` `add`.
- `DATA_WIDTH`, 32, data word width.
- `INDEX_WIDTH`, 6, line index bits (64 lines, one word per line); tag = `ADDR_WIDTH-INDEX_WIDTH` bits.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  ADDR_WIDTH  CPU word address, held until `cpu_ready`.
- `cpu_wdata`  in  DATA_WIDTH  store data, held until `cpu_ready`.
- `cpu_read`  in  1  load request, level, held until `cpu_ready`.
- `cpu_write`  in  1  store request, level, held until `cpu_ready`.
- `cpu_rdata`  out  DATA_WIDTH  load data, valid while `cpu_ready`=1 for a load.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `mem_add`  out  ADDR_WIDTH  address to `main_memory`.
- `mem_write_data`  out  DATA_WIDTH  store data to `main_memory`.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `mem_read_data`  in  DATA_WIDTH  memory read data.
- `mem_ready`  in  1  memory completion.

## Operation
- FSM states: IDLE, MEM_RD, MEM_WR, RESP. All outputs are registered.
- In IDLE, the request is sampled at each edge. `cpu_write` has priority over `cpu_read`, as in memory.
  - Read hit (valid[idx] and tag match): `cpu_rdata`<=data[idx]; go to RESP.
  - Read miss: latch the address; `mem_add`<=`cpu_addr`; `mem_read`<=1; go to MEM_RD.
  - Write: latch the address and data; `mem_write`<=1. On a hit, data[idx]<=`cpu_wdata` in the same edge. On a miss, the line is untouched. Go to MEM_WR.
- MEM_RD / MEM_WR: hold the request.
  - A `first` flag ignores `mem_ready` on the first edge of each request, because the value sampled there predates the request and can be stale.
  - On a later edge with `mem_ready`=1:
    - From MEM_RD: fill the line (valid=1, tag, data=`mem_read_data`) and set `cpu_rdata`<=`mem_read_data`.
    - From both states: drop `mem_read`/`mem_write` and go to RESP.
- RESP: `cpu_ready`=1 for exactly one cycle, then IDLE. `cpu_rdata` holds its value until the next load completes.
- Reset:
  - All valid bits are cleared, state goes to IDLE, and `cpu_ready`, `mem_read`, `mem_write`, `cpu_rdata`, `mem_add` and `mem_write_data` are forced to 0.
  - Reset mid-transaction aborts immediately, with no fill and no `cpu_ready`.
- Both `cpu_read` and `cpu_write` at 0 in IDLE: stay in IDLE, outputs unchanged.

## Timing
- The request is first sampled at edge E.
- Read hit: `cpu_ready` high in the cycle after E, so latency is 1.
- Read miss and any write: request high from E to E+2, `mem_ready` accepted at E+2, `cpu_ready` high in cycle E+2..E+3. Latency is 3.
- Memory re-samples the held request at E+2; this is idempotent.
- The CPU changes or drops its request at the edge ending the `cpu_ready` cycle. That edge brings the FSM back to IDLE, so the next request is sampled one edge later.
  - Back-to-back hits therefore complete every 2 cycles.
- `mem_read` and `mem_write` are never both 1. There is at least one idle cycle between memory transactions.

## Structure
- Package `cache_pkg` holds:
  - the state enum;
  - derived widths `TAG_WIDTH` and `LINES`;
  - index/tag slice helper functions.
- Sub-module `cache_array` holds the valid, tag and data storage: one read port plus one write port, valid bits cleared asynchronously by `reset`.
- The FSM and memory handshake live in `data_cache`.

## Test plan
- Cold read: after reset, read 0x005 with mem[0x005]=0xDEADBEEF. Required: `mem_read` for 2 cycles, then `cpu_ready` at latency 3 with `cpu_rdata`=0xDEADBEEF.
- Hit after fill: read 0x005 again. Required: `cpu_ready` at latency 1, data 0xDEADBEEF, `mem_read` stays 0.
- Write hit: write 0x12345678 to 0x005. Required: memory word updated, latency 3. A subsequent read hits with 0x12345678.
- Conflict miss / no-allocate:
  - Write 0xAAAA0000 to 0x045 (same index as 0x005). Required: line 5 still holds tag for 0x005.
  - Then read 0x045. Required: miss, refill, data 0xAAAA0000.
  - Then read 0x005. Required: miss.
- Simultaneous `cpu_read`=`cpu_write`=1 at 0x010. Required: only `mem_write` is asserted, and the store completes.
- Reset asserted during MEM_RD. Required: `mem_read`=0 asynchronously, no `cpu_ready`, and a following read of the same address misses.
